// File: rtl/fe_pkg.sv
// Shared GF(2^255-19) constants, element type and inversion-sequencer state encoding.
package fe_pkg;

  localparam int FE_BITS = 255;
  localparam int FE_C    = 19;

  typedef logic [FE_BITS-1:0] fe_t;

  // 2^255 - 19: all ones except the low five bits 01101.
  localparam fe_t FE_P   = {{(FE_BITS-5){1'b1}}, 5'b01101};
  localparam fe_t FE_EXP = FE_P - fe_t'(2);

  typedef enum logic [2:0] {
    ST_GUARD,
    ST_IDLE,
    ST_SQR_ISSUE,
    ST_SQR_WAIT,
    ST_MUL_ISSUE,
    ST_MUL_WAIT,
    ST_FIN
  } feinv_state_t;

  function automatic logic exp_bit(input logic [7:0] idx);
    if (idx >= 8'(FE_BITS)) return 1'b0;
    return FE_EXP[idx];
  endfunction

endpackage

// File: rtl/fe_freeze.sv
// Combinational canonical reduction of a 255-bit value into [0, p-1].
module fe_freeze
  import fe_pkg::*;
(
  input  fe_t r_i,
  output fe_t r_o
);

  localparam logic [FE_BITS:0] C_EXT = (FE_BITS+1)'(FE_C);

  logic [FE_BITS:0] t;

  // r >= p exactly when r + 19 carries into bit 255; the low bits are then r - p.
  assign t   = {1'b0, r_i} + C_EXT;
  assign r_o = t[FE_BITS] ? t[FE_BITS-1:0] : r_i;

endmodule

// File: rtl/feinv_seq.sv
// Fermat inversion a^(p-2) mod p driven through an external field multiplier.
// Define FEINV_FREEZE_EN to canonicalise the result in the final cycle.
module feinv_seq
  import fe_pkg::*;
#(
  parameter int MUL_GUARD = 40,
  parameter int IDX_W     = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  fe_t  a_in,
  output logic busy,
  output logic done,
  output fe_t  out,
  output logic mul_start,
  output fe_t  mul_a,
  output fe_t  mul_b,
  input  logic mul_done,
  input  fe_t  mul_out
);

  localparam int               GW         = $clog2(MUL_GUARD + 2);
  localparam logic [GW-1:0]    GUARD_INIT = GW'(MUL_GUARD);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(FE_BITS - 2);

  feinv_state_t     state_q, state_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  fe_t              a_q, a_d;
  fe_t              r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  fe_t              out_q, out_d;
  logic             mul_start_q, mul_start_d;
  fe_t              mul_a_q, mul_a_d;
  fe_t              mul_b_q, mul_b_d;
  fe_t              fin_val;
  logic             mul_ack;

`ifdef FEINV_FREEZE_EN
  fe_freeze u_freeze (
    .r_i (r_q),
    .r_o (fin_val)
  );
`else
  assign fin_val = r_q;
`endif

  // A completion coinciding with our own start pulse can only be a leftover.
  assign mul_ack = mul_done && !mul_start_q;

  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    idx_d       = idx_q;
    a_d         = a_q;
    r_d         = r_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_d       = out_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    case (state_q)
      ST_GUARD: begin
        if (guard_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          r_d     = a_in;
          idx_d   = IDX_TOP;
          busy_d  = 1'b1;
          state_d = ST_SQR_ISSUE;
        end
      end
      ST_SQR_ISSUE: begin
        mul_a_d     = r_q;
        mul_b_d     = r_q;
        mul_start_d = 1'b1;
        state_d     = ST_SQR_WAIT;
      end
      ST_SQR_WAIT: begin
        if (mul_ack) begin
          r_d = mul_out;
          if (exp_bit(8'(idx_q))) begin
            state_d = ST_MUL_ISSUE;
          end else if (idx_q == '0) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_SQR_ISSUE;
          end
        end
      end
      ST_MUL_ISSUE: begin
        mul_a_d     = r_q;
        mul_b_d     = a_q;
        mul_start_d = 1'b1;
        state_d     = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (mul_ack) begin
          r_d = mul_out;
          if (idx_q == '0) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_SQR_ISSUE;
          end
        end
      end
      ST_FIN: begin
        out_d   = fin_val;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_GUARD;
        guard_d = GUARD_INIT;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_GUARD;
      guard_q     <= GUARD_INIT;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      out_q       <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_q       <= out_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  // Working operands carry no reset; they are always loaded on an accepted start.
  always_ff @(posedge clock) begin
    idx_q <= idx_d;
    a_q   <= a_d;
    r_q   <= r_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_feinv_seq.sv
// Scoreboard bench for feinv_seq with a behavioural modular multiplier of variable latency.
module tb_feinv_seq;

  typedef logic [254:0] fe_t;
  typedef struct {
    fe_t    expv;
    longint t0;
    int     lat;
  } txn_t;

  localparam int  MUL_GUARD = 40;
  localparam int  N_MUL     = 506;
  localparam fe_t P         = fe_t'((256'd1 << 255) - 256'd19);

  logic clock = 1'b0;
  logic reset, start, busy, done, mul_start;
  logic mul_done = 1'b0;
  fe_t  a_in, res_out, mul_a, mul_b;
  fe_t  mul_out = '0;

  int     n_vec = 0;
  int     n_fail = 0;
  longint cyc = 0;
  int     mul_lat = 2;
  int     mul_cnt = 0;
  logic   pend = 1'b0;
  int     cnt = 0;
  fe_t    ma = '0;
  fe_t    mb = '0;
  txn_t   sb[$];

  feinv_seq #(.MUL_GUARD(MUL_GUARD), .IDX_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .a_in      (a_in),
    .busy      (busy),
    .done      (done),
    .out       (res_out),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_out   (mul_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic fe_t mulmod(input fe_t x, input fe_t y);
    logic [509:0] prod, pw;
    prod = {255'd0, x} * {255'd0, y};
    pw   = {255'd0, P};
    return fe_t'(prod % pw);
  endfunction

  // Right-to-left binary exponentiation by p-2.
  function automatic fe_t ref_inv(input fe_t x);
    fe_t res, base, e;
    res  = fe_t'(1);
    base = mulmod(x, fe_t'(1));
    e    = P - fe_t'(2);
    for (int i = 0; i < 255; i++) begin
      if (e[i]) res = mulmod(res, base);
      base = mulmod(base, base);
    end
    return res;
  endfunction

  function automatic fe_t rand_fe();
    fe_t v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[222:0], 32'($urandom)};
    return v;
  endfunction

  function automatic void chk(input string name, input fe_t act, input fe_t req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  function automatic void chk_cond(input string name, input bit ok, input longint act, input longint req);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  // Multiplier: done arrives mul_lat cycles after the cycle in which mul_start is high.
  always @(posedge clock) begin
    mul_done <= 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        mul_done <= 1'b1;
        mul_out  <= mulmod(ma, mb);
        pend     <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (mul_start) begin
      if (mul_lat <= 1) begin
        mul_done <= 1'b1;
        mul_out  <= mulmod(mul_a, mul_b);
      end else begin
        pend <= 1'b1;
        cnt  <= mul_lat - 1;
        ma   <= mul_a;
        mb   <= mul_b;
      end
    end
  end

  // Monitor: latency counts cycles from the start cycle to the done cycle inclusive.
  initial begin
    txn_t   t;
    longint lat;
    forever begin
      @(negedge clock);
      if (reset) begin
        mul_cnt = 0;
      end else begin
        if (mul_start) begin
          mul_cnt++;
          chk_cond("one_outstanding", !pend, longint'(pend), 0);
        end
        if (done) begin
          if (sb.size() == 0) begin
            chk_cond("spurious_done", 1'b0, 1, 0);
          end else begin
            t   = sb.pop_front();
            lat = cyc - t.t0 + 1;
            chk("out", res_out, t.expv);
            chk_cond("mul_start_count", mul_cnt == N_MUL, mul_cnt, N_MUL);
            chk_cond("latency", lat == longint'(N_MUL * (t.lat + 2) + 3), lat,
                     longint'(N_MUL * (t.lat + 2) + 3));
            chk_cond("busy_at_done", !busy, longint'(busy), 0);
          end
          mul_cnt = 0;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk_cond({tag, "_busy"}, busy === 1'b1, longint'(busy), 1);
    chk_cond({tag, "_done"}, done === 1'b0, longint'(done), 0);
    chk_cond({tag, "_mul_start"}, mul_start === 1'b0, longint'(mul_start), 0);
    chk({tag, "_out"}, res_out, '0);
    chk({tag, "_mul_a"}, mul_a, '0);
    chk({tag, "_mul_b"}, mul_b, '0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic issue(input fe_t a, input fe_t expv, input int lat);
    int n;
    wait_idle(n);
    if (busy) chk_cond("idle_timeout", 1'b0, n, 0);
    mul_lat = lat;
    a_in    = a;
    start   = 1'b1;
    sb.push_back('{expv, cyc, lat});
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 6000 && sb.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      chk_cond("done_timeout", 1'b0, i, 0);
      sb.delete();
    end
  endtask

  task automatic run_op(input fe_t a, input fe_t expv, input int lat);
    issue(a, expv, lat);
    wait_done();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int   n;
    int   k;
    fe_t  a;
    fe_t  inv2, inv3;
    logic [256:0] w;

    w    = ({2'b0, P} + 257'd1) >> 1;
    inv2 = fe_t'(w);
    w    = ({2'b0, P} * 257'd2 + 257'd1) / 257'd3;
    inv3 = fe_t'(w);

    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    wait_idle(n);
    chk_cond("guard_len", n >= MUL_GUARD && n <= MUL_GUARD + 1, n, MUL_GUARD);

    run_op(fe_t'(1), fe_t'(1), 2);
    run_op(fe_t'(2), inv2, 1);
    chk("two_times_inv", mulmod(fe_t'(2), res_out), fe_t'(1));
    run_op('0, '0, 3);
    run_op(P - fe_t'(1), P - fe_t'(1), 4);
    run_op(P + fe_t'(1), fe_t'(1), 2);

    // Start ignored while busy: operand changes mid-run must not matter.
    a = rand_fe();
    issue(a, ref_inv(a), 2);
    for (k = 0; k < 100 && !mul_start; k++) begin
      @(posedge clock);
      #1;
    end
    a_in  = rand_fe();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done();

    // Reset on the 100th multiplier start, with a competing start request.
    a = rand_fe();
    issue(a, ref_inv(a), 3);
    n = 0;
    for (k = 0; k < 2000; k++) begin
      if (mul_start) n++;
      if (n == 100) break;
      @(posedge clock);
      #1;
    end
    chk_cond("reach_100th_mul", n == 100, n, 100);
    reset = 1'b1;
    start = 1'b1;
    a_in  = rand_fe();
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check_reset_vals("midrst");
    wait_idle(n);
    chk_cond("guard_len_mid", n >= MUL_GUARD && n <= MUL_GUARD + 1, n, MUL_GUARD);
    run_op(fe_t'(3), inv3, 3);

    for (int r = 0; r < 5; r++) begin
      a = rand_fe();
      run_op(a, ref_inv(a), int'($urandom_range(1, 4)));
    end

    repeat (5) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
